// File: rtl/cmp_pkg.sv
// Shared comparator result codes and helpers used by the filter and the comparator benches.
package cmp_pkg;

  typedef logic [1:0] cmp_code_t;

  localparam cmp_code_t CMP_NONE = 2'b00;
  localparam cmp_code_t CMP_EQ   = 2'b01;
  localparam cmp_code_t CMP_GT   = 2'b10;
  localparam cmp_code_t CMP_LT   = 2'b11;

  // Expands a code into the {gt, lt, eq} flag triple; NONE maps to all-zero.
  function automatic logic [2:0] cmp_onehot(input cmp_code_t code);
    logic [2:0] flags;
    flags = '0;
    case (code)
      CMP_GT:  flags = 3'b100;
      CMP_LT:  flags = 3'b010;
      CMP_EQ:  flags = 3'b001;
      default: flags = '0;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/cmp_flag_decode.sv
// Combinational decode of the comparator's one-hot flags into a result code.
module cmp_flag_decode
  import cmp_pkg::*;
(
  input  logic      a_gt_b,
  input  logic      a_lt_b,
  input  logic      a_eq_b,
  output cmp_code_t code,
  output logic      illegal
);

  always_comb begin
    code    = CMP_NONE;
    illegal = 1'b0;
    case ({a_gt_b, a_lt_b, a_eq_b})
      3'b100:  code = CMP_GT;
      3'b010:  code = CMP_LT;
      3'b001:  code = CMP_EQ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cmp_result_filter.sv
// Debounces comparator flags into a stable result; pulses on change and on illegal flags.
module cmp_result_filter
  import cmp_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  output logic             stable_vld,
  output logic             stable_gt,
  output logic             stable_lt,
  output logic             stable_eq,
  output logic             changed,
  output logic             err,
  output logic [CNT_W-1:0] change_cnt
);

  localparam int unsigned         RUN_W   = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0]    RUN_END = RUN_W'(DEBOUNCE);

  cmp_code_t        code;
  logic             illegal;

  // stable_q doubles as the FSM state: CMP_NONE is the UNKNOWN state.
  cmp_code_t        stable_q, stable_d;
  cmp_code_t        cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             vld_d, changed_d, err_d;
  logic [CNT_W-1:0] cnt_d;

  cmp_code_t        cand_upd;
  logic [RUN_W-1:0] run_upd;

  cmp_flag_decode u_decode (
    .a_gt_b  (a_gt_b),
    .a_lt_b  (a_lt_b),
    .a_eq_b  (a_eq_b),
    .code    (code),
    .illegal (illegal)
  );

  always_comb begin
    stable_d  = stable_q;
    cand_d    = cand_q;
    run_d     = run_q;
    vld_d     = stable_vld;
    cnt_d     = change_cnt;
    changed_d = 1'b0;
    err_d     = 1'b0;
    cand_upd  = cand_q;
    run_upd   = run_q;

    if (in_valid) begin
      if (illegal) begin
        err_d  = 1'b1;
        cand_d = CMP_NONE;
        run_d  = '0;
      end else if (code == stable_q) begin
        cand_d = CMP_NONE;
        run_d  = '0;
      end else begin
        if (code == cand_q) begin
          run_upd = run_q + 1'b1;
        end else begin
          cand_upd = code;
          run_upd  = RUN_W'(1);
        end

        if (run_upd == RUN_END) begin
          stable_d  = cand_upd;
          vld_d     = 1'b1;
          changed_d = 1'b1;
          if (change_cnt != '1) begin
            cnt_d = change_cnt + 1'b1;
          end
          cand_d = CMP_NONE;
          run_d  = '0;
        end else begin
          cand_d = cand_upd;
          run_d  = run_upd;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q   <= CMP_NONE;
      cand_q     <= CMP_NONE;
      run_q      <= '0;
      stable_vld <= 1'b0;
      stable_gt  <= 1'b0;
      stable_lt  <= 1'b0;
      stable_eq  <= 1'b0;
      changed    <= 1'b0;
      err        <= 1'b0;
      change_cnt <= '0;
    end else begin
      stable_q   <= stable_d;
      cand_q     <= cand_d;
      run_q      <= run_d;
      stable_vld <= vld_d;
      {stable_gt, stable_lt, stable_eq} <= cmp_onehot(stable_d);
      changed    <= changed_d;
      err        <= err_d;
      change_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cmp_result_filter.sv
// Scoreboard bench for cmp_result_filter: an 8-bit-counter DUT and a 2-bit-counter DUT share stimulus.
module tb_cmp_result_filter;

  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       a_gt_b = 1'b0, a_lt_b = 1'b0, a_eq_b = 1'b0;

  logic       vld_a, gt_a, lt_a, eq_a, chg_a, err_a;
  logic [7:0] cnt_a;
  logic       vld_b, gt_b, lt_b, eq_b, chg_b, err_b;
  logic [1:0] cnt_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int vld, gt, lt, eq, chg, err, cnt8, cnt2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: 0 none, 1 eq, 2 gt, 3 lt.
  int m_stable, m_cand, m_run, m_vld, m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  cmp_result_filter #(.DEBOUNCE(DEB), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
    .stable_vld(vld_a), .stable_gt(gt_a), .stable_lt(lt_a), .stable_eq(eq_a),
    .changed(chg_a), .err(err_a), .change_cnt(cnt_a)
  );

  cmp_result_filter #(.DEBOUNCE(DEB), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
    .stable_vld(vld_b), .stable_gt(gt_b), .stable_lt(lt_b), .stable_eq(eq_b),
    .changed(chg_b), .err(err_b), .change_cnt(cnt_b)
  );

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_stable = 0; m_cand = 0; m_run = 0; m_vld = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic model_step(input logic v, input logic [2:0] f, output exp_t e);
    int c;
    e.chg = 0;
    e.err = 0;
    if (f == 3'b100)      c = 2;
    else if (f == 3'b010) c = 3;
    else if (f == 3'b001) c = 1;
    else                  c = -1;
    if (v) begin
      if (c < 0) begin
        e.err = 1; m_cand = 0; m_run = 0;
      end else if (c == m_stable) begin
        m_cand = 0; m_run = 0;
      end else begin
        if (c == m_cand) m_run++;
        else begin m_cand = c; m_run = 1; end
        if (m_run == DEB) begin
          m_stable = m_cand; m_vld = 1; e.chg = 1;
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
          m_cand = 0; m_run = 0;
        end
      end
    end
    e.vld  = m_vld;
    e.gt   = (m_stable == 2) ? 1 : 0;
    e.lt   = (m_stable == 3) ? 1 : 0;
    e.eq   = (m_stable == 1) ? 1 : 0;
    e.cnt8 = m_cnt8;
    e.cnt2 = m_cnt2;
  endtask

  // Drive one sample, let it be clocked in, then compare both DUTs against the scoreboard.
  task automatic step(input logic v, input logic [2:0] f);
    exp_t e;
    in_valid = v;
    {a_gt_b, a_lt_b, a_eq_b} = f;
    model_step(v, f, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("vld", vld_a, e.vld);
      chk("gt", gt_a, e.gt);
      chk("lt", lt_a, e.lt);
      chk("eq", eq_a, e.eq);
      chk("changed", chg_a, e.chg);
      chk("err", err_a, e.err);
      chk("cnt8", cnt_a, e.cnt8);
      chk("b_flags", {vld_b, gt_b, lt_b, eq_b}, {e.vld[0], e.gt[0], e.lt[0], e.eq[0]});
      chk("b_changed", chg_b, e.chg);
      chk("b_cnt2", cnt_b, e.cnt2);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, {vld_a, gt_a, lt_a, eq_a, chg_a, err_a, cnt_a}, 0);
    chk({tag, "_b"}, {vld_b, gt_b, lt_b, eq_b, chg_b, err_b, cnt_b}, 0);
  endtask

  localparam logic [2:0] GT = 3'b100, LT = 3'b010, EQ = 3'b001;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three EQ establish the first result
    repeat (3) step(1'b1, EQ);
    chk("t1_eq", eq_a, 1);
    chk("t1_cnt", cnt_a, 1);
    step(1'b0, EQ);
    chk("t1_pulse_end", chg_a, 0);

    // 2: interrupted GT run, then a full one
    step(1'b1, GT); step(1'b1, GT); step(1'b1, EQ);
    step(1'b1, GT); step(1'b1, GT);
    chk("t2_hold_eq", eq_a, 1);
    step(1'b1, GT);
    chk("t2_gt", gt_a, 1);
    chk("t2_cnt", cnt_a, 2);

    // 3: invalid gaps do not break a run
    step(1'b1, LT);
    repeat (4) step(1'b0, 3'b000);
    step(1'b1, LT); step(1'b1, LT);
    chk("t3_lt", lt_a, 1);
    chk("t3_cnt", cnt_a, 3);

    // 4: illegal pattern mid-run restarts the run
    step(1'b1, GT); step(1'b1, GT); step(1'b1, 3'b110);
    chk("t4_err", err_a, 1);
    step(1'b1, GT); step(1'b1, GT);
    chk("t4_still_lt", lt_a, 1);
    step(1'b1, GT);
    chk("t4_gt", gt_a, 1);

    // 5: asynchronous reset between edges mid-run
    step(1'b1, EQ); step(1'b1, EQ);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, GT); step(1'b1, GT);
    chk("t5_vld", vld_a, 0);

    // 6: alternating full runs drive the 2-bit counter into saturation
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < DEB; k++) step(1'b1, (r % 2 == 0) ? LT : GT);
    end
    chk("t6_sat", cnt_b, 3);

    // Random mix including illegal patterns and idle cycles
    for (int i = 0; i < 300; i++) begin
      logic [2:0] f;
      case ($urandom_range(0, 9))
        0:       f = 3'($urandom_range(0, 7));
        1, 2, 3: f = GT;
        4, 5, 6: f = LT;
        default: f = EQ;
      endcase
      step(($urandom_range(0, 4) != 0), f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
